// File: rtl/rgb_code_pkg.sv
// Shared colour-code definitions for the RGB decoder and encoder: legal
// patterns, 2-bit codes, encoder FSM states and the pattern-to-code mapping.
package rgb_code_pkg;

    localparam logic [2:0] RGB_C0 = 3'b111;
    localparam logic [2:0] RGB_C1 = 3'b100;
    localparam logic [2:0] RGB_C2 = 3'b010;
    localparam logic [2:0] RGB_C3 = 3'b110;

    localparam logic [1:0] CODE_0 = 2'b00;
    localparam logic [1:0] CODE_1 = 2'b01;
    localparam logic [1:0] CODE_2 = 2'b10;
    localparam logic [1:0] CODE_3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } enc_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] code;
    } rgb_dec_t;

    // Illegal patterns return legal=0 with a don't-care code of 00.
    function automatic rgb_dec_t rgb_to_code(input logic [2:0] pat);
        rgb_dec_t res;
        res.legal = 1'b1;
        res.code  = CODE_0;
        case (pat)
            RGB_C0:  res.code = CODE_0;
            RGB_C1:  res.code = CODE_1;
            RGB_C2:  res.code = CODE_2;
            RGB_C3:  res.code = CODE_3;
            default: res.legal = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg[gi] <= RST_VAL[gi];
                    sync_reg[gi] <= RST_VAL[gi];
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/rgb_encoder.sv
// Synchronises and debounces a 3-bit RGB pin pattern and converts each newly
// accepted pattern into its 2-bit colour code, flagging illegal patterns.
module rgb_encoder
    import rgb_code_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rgb_in,
    output logic [1:0] code,
    output logic       code_valid,
    output logic       code_err,
    output logic       busy
);

    // Final count before acceptance: cnt+1 == DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       s;
    enc_state_t       state_reg, state_next;
    logic [2:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       acc_pat_reg, acc_pat_next;
    logic [1:0]       code_reg, code_next;
    logic             code_valid_reg, code_valid_next;
    logic             code_err_reg, code_err_next;
    rgb_dec_t         cand_dec;

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL (RGB_C0)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rgb_in),
        .q   (s)
    );

    assign cand_dec = rgb_to_code(cand_reg);

    always_comb begin
        state_next      = state_reg;
        cand_next       = cand_reg;
        cnt_next        = cnt_reg;
        acc_pat_next    = acc_pat_reg;
        code_next       = code_reg;
        code_valid_next = 1'b0;
        code_err_next   = code_err_reg;
        case (state_reg)
            IDLE: begin
                if (s != acc_pat_reg) begin
                    cand_next  = s;
                    cnt_next   = CNT_ONE;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (s == acc_pat_reg) begin
                    state_next = IDLE;
                end else if (s != cand_reg) begin
                    cand_next = s;
                    cnt_next  = CNT_ONE;
                end else if (cnt_reg == CNT_LAST) begin
                    acc_pat_next = cand_reg;
                    state_next   = IDLE;
                    if (cand_dec.legal) begin
                        code_next       = cand_dec.code;
                        code_valid_next = 1'b1;
                        code_err_next   = 1'b0;
                    end else begin
                        // code holds its last legal value while the error is flagged
                        code_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cand_reg       <= RGB_C0;
            cnt_reg        <= '0;
            acc_pat_reg    <= RGB_C0;
            code_reg       <= CODE_0;
            code_valid_reg <= 1'b0;
            code_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cand_reg       <= cand_next;
            cnt_reg        <= cnt_next;
            acc_pat_reg    <= acc_pat_next;
            code_reg       <= code_next;
            code_valid_reg <= code_valid_next;
            code_err_reg   <= code_err_next;
        end
    end

    assign code       = code_reg;
    assign code_valid = code_valid_reg;
    assign code_err   = code_err_reg;
    assign busy       = (state_reg == SETTLE);

endmodule

// File: doc/rgb_encoder.md
# rgb_encoder

Encoder for the 2-bit colour-code / 3-bit RGB mapping, running in the opposite direction to the switch-to-LED decoder. It samples a 3-bit RGB pattern from asynchronous board pins, synchronises and debounces it, and converts each stable legal pattern back to its 2-bit code with a one-cycle valid strobe. It flags patterns outside the legal set. It sits between the RGB input pins and any logic that consumes the 2-bit colour code.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required before a pattern is accepted. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter. It is derived and must not be overridden.

Ports:
- `clk` input, 1 bit: the only clock. All logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rgb_in` input, 3 bits: raw RGB pattern, asynchronous to `clk`.
- `code` output, 2 bits: code of the last accepted legal pattern.
- `code_valid` output, 1 bit: one-cycle pulse when `code` is updated by an acceptance.
- `code_err` output, 1 bit: level. It is 1 while the last accepted pattern is illegal.
- `busy` output, 1 bit: 1 while the FSM is in SETTLE.

## Operation
- Mapping: 111→00, 100→01, 010→10, 110→11.
  - Illegal patterns: 000, 001, 011, 101.
- Synchroniser:
  - `rgb_in` passes through 2 flops. The second flop gives the sample `s`.
  - Both flops reset to 3'b111.
- Internal registers:
  - `acc_pat` (3 bits) holds the last accepted raw pattern, legal or illegal. It resets to 3'b111.
  - `cand` (3 bits) and `cnt` (`CNT_W` bits) track the pattern being debounced.
- FSM states are IDLE and SETTLE.
- IDLE:
  - If `s != acc_pat`, load `cand=s`, set `cnt=1` and go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE, evaluated in this order at each edge:
  1. `s == acc_pat`: go to IDLE. No strobe, outputs unchanged (a glitch back).
  2. `s != cand`: load `cand=s`, set `cnt=1` and stay in SETTLE (restart).
  3. `s == cand` and `cnt+1 == DEBOUNCE_CYCLES`: accept, set `acc_pat=cand` and go to IDLE.
  4. Otherwise set `cnt=cnt+1`.
- Accept, legal `cand`: `code` gets the mapped value, `code_valid=1` for exactly one cycle, `code_err=0`.
- Accept, illegal `cand`: `code` is held, `code_valid=0`, `code_err=1`.
  - `code_err` stays 1 until a legal pattern is accepted.
- Re-accepting the same pattern cannot happen, because IDLE leaves only when `s != acc_pat`.
  - Hence no duplicate strobes and no re-raising of `code_err`.
- Reset values: `code=2'b00`, `code_valid=0`, `code_err=0`, `busy=0`, FSM=IDLE, `cnt=0`, `cand=3'b111`.
- Reset mid-SETTLE:
  - The candidate is discarded and all state returns to its reset values immediately (asynchronous).
  - If `rgb_in` is not 111 after reset, a fresh debounce starts from IDLE.

## Timing
- All outputs are registered, with no combinational path from `rgb_in`.
- Latency for `rgb_in` changing to a new pattern and staying stable:
  - Call the first edge that captures the new pattern into sync flop 1 edge E1.
  - The FSM sees it at edge E1+2 and enters SETTLE with `cnt=1`.
  - Acceptance happens at edge E1+1+`DEBOUNCE_CYCLES`.
  - `code`/`code_valid`/`code_err` are visible in the cycle after that edge.
  - With default 16, the strobe is visible after edge E1+17.
- `busy` is 1 from edge E1+2 through the accept edge, and falls with the same edge that raises `code_valid`.
- Any instability restarts the count. Minimum stable time is `DEBOUNCE_CYCLES` sampled cycles.
- `code_valid` pulses are separated by at least `DEBOUNCE_CYCLES` cycles.
- The counter never wraps: `cnt` ≤ `DEBOUNCE_CYCLES-1` in SETTLE.

## Structure
- Shared package `rgb_code_pkg`, which the decoder and encoder both import so the two directions cannot drift:
  - localparams for the four legal patterns (`RGB_C0=3'b111`, `RGB_C1=3'b100`, `RGB_C2=3'b010`, `RGB_C3=3'b110`).
  - the 2-bit code constants.
  - the FSM state typedef (`IDLE`, `SETTLE`).
- Sub-module `sync_2ff`, parameterised by width and reset value, used for the synchroniser.
- The pattern→code mapping and legality check are a combinational function in `rgb_code_pkg`.

## Test plan
Use `DEBOUNCE_CYCLES=4` unless stated otherwise.
- Reset and idle: hold `rst` high, then release with `rgb_in=111` for 50 cycles → `code=00`, `code_valid` never 1, `code_err=0`, `busy=0`.
- Clean change: `rgb_in` 111→100 at E1, held → `code_valid` visible exactly after edge E1+5, `code=01`, `busy` high for E1+2..E1+5.
  - Then 100→110 → `code=11` with one pulse.
- Bounce: `rgb_in` toggles 111/010 every 2 cycles for 20 cycles, then holds 010 → no strobe during the toggling, one strobe with `code=10` 5 edges after the final capture.
- Glitch back: 111→100 for 2 cycles, then 111 → `busy` rises then falls, no strobe, `code=00`.
- Illegal pattern: hold 011 → `code_err=1` after 5 edges, `code` unchanged, no strobe.
  - Hold 000 next → `code_err` stays 1.
  - Then 010 → `code_err=0`, `code=10`, one strobe.
- Reset mid-SETTLE: 111→100, assert `rst` at `cnt=2` → all outputs immediately return to reset values.
  - After release with 100 still held → acceptance occurs exactly 1+`DEBOUNCE_CYCLES` edges after the first capture edge, with `code=01`.
